// File: rtl/counter_seq_ctrl.sv
// counter_seq_ctrl: run/stop/step sequencer for the mod-MOD counter datapath.
// Accepts commands over valid/ready and divides clk into count ticks. It
// drives registered enable/load/clear pulses and watches the counter value
// to handle the terminal count.
module counter_seq_ctrl #(
    parameter int MOD       = 12,
    parameter int PRESC_DIV = 12000000,
    parameter int PRESC_W   = 24
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [2:0] cmd_op,
    input  logic [3:0] cmd_data,
    input  logic [3:0] count,
    output logic       cnt_en,
    output logic       cnt_up,
    output logic       cnt_load,
    output logic [3:0] load_val,
    output logic       cnt_clr,
    output logic [1:0] state,
    output logic       done,
    output logic       cmd_err
);

    localparam logic [1:0] ST_STOPPED  = 2'd0;
    localparam logic [1:0] ST_RUNNING  = 2'd1;
    localparam logic [1:0] ST_STEPPING = 2'd2;
    localparam logic [1:0] ST_HALT_TC  = 2'd3;

    localparam logic [2:0] OP_RUN      = 3'd1;
    localparam logic [2:0] OP_STOP     = 3'd2;
    localparam logic [2:0] OP_STEP     = 3'd3;
    localparam logic [2:0] OP_LOAD     = 3'd4;
    localparam logic [2:0] OP_CLEAR    = 3'd5;
    localparam logic [2:0] OP_SET_DIR  = 3'd6;
    localparam logic [2:0] OP_SET_MODE = 3'd7;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(PRESC_DIV - 1);
    localparam logic [3:0]         CNT_MAX    = 4'(MOD - 1);
    localparam logic [4:0]         MOD_V      = 5'(MOD);

    logic [1:0]         state_q, state_d;
    logic [PRESC_W-1:0] presc_q, presc_d;
    logic               cnt_up_q, cnt_up_d;
    logic               oneshot_q, oneshot_d;
    // Set when RUN leaves HALT_TC: the next tick must step through the wrap
    // instead of halting again on the same terminal value.
    logic               pass_tc_q, pass_tc_d;
    logic               cnt_en_q, cnt_en_d;
    logic               cnt_load_q, cnt_load_d;
    logic [3:0]         load_val_q, load_val_d;
    logic               cnt_clr_q, cnt_clr_d;
    logic               done_q, done_d;
    logic               cmd_err_q, cmd_err_d;

    logic accept;
    logic at_tc;
    logic tick;

    assign cmd_ready = (state_q != ST_STEPPING);
    assign state     = state_q;
    assign cnt_up    = cnt_up_q;
    assign cnt_en    = cnt_en_q;
    assign cnt_load  = cnt_load_q;
    assign load_val  = load_val_q;
    assign cnt_clr   = cnt_clr_q;
    assign done      = done_q;
    assign cmd_err   = cmd_err_q;

    // Next-state decision: stepping first, then an accepted command, then the tick.
    always_comb begin
        accept     = cmd_valid && cmd_ready;
        at_tc      = cnt_up_q ? (count == CNT_MAX) : (count == 4'd0);
        tick       = (state_q == ST_RUNNING) && (presc_q == PRESC_LAST);

        state_d    = state_q;
        presc_d    = presc_q;
        cnt_up_d   = cnt_up_q;
        oneshot_d  = oneshot_q;
        pass_tc_d  = pass_tc_q;
        cnt_en_d   = 1'b0;
        cnt_load_d = 1'b0;
        load_val_d = load_val_q;
        cnt_clr_d  = 1'b0;
        done_d     = 1'b0;
        cmd_err_d  = 1'b0;

        if (state_q == ST_RUNNING) begin
            presc_d = tick ? '0 : presc_q + 1'b1;
        end

        if (state_q == ST_STEPPING) begin
            // Manual step ignores the terminal count, so it wraps in one-shot too.
            cnt_en_d = 1'b1;
            state_d  = ST_STOPPED;
        end else if (accept) begin
            // Any accepted command takes precedence over a coincident tick.
            case (cmd_op)
                OP_RUN: begin
                    if (state_q != ST_RUNNING) begin
                        pass_tc_d = (state_q == ST_HALT_TC);
                        state_d   = ST_RUNNING;
                        presc_d   = '0;
                    end
                end
                OP_STOP: begin
                    if (state_q != ST_STOPPED) begin
                        state_d   = ST_STOPPED;
                        presc_d   = '0;
                        pass_tc_d = 1'b0;
                    end
                end
                OP_STEP: begin
                    if (state_q != ST_RUNNING) begin
                        state_d   = ST_STEPPING;
                        pass_tc_d = 1'b0;
                    end
                end
                OP_LOAD: begin
                    if ({1'b0, cmd_data} < MOD_V) begin
                        cnt_load_d = 1'b1;
                        load_val_d = cmd_data;
                        presc_d    = '0;
                        pass_tc_d  = 1'b0;
                    end else begin
                        cmd_err_d  = 1'b1;
                    end
                    if (state_q == ST_HALT_TC) begin
                        state_d = ST_STOPPED;
                    end
                end
                OP_CLEAR: begin
                    cnt_clr_d = 1'b1;
                    presc_d   = '0;
                    pass_tc_d = 1'b0;
                    if (state_q == ST_HALT_TC) begin
                        state_d = ST_STOPPED;
                    end
                end
                OP_SET_DIR:  cnt_up_d  = cmd_data[0];
                OP_SET_MODE: oneshot_d = cmd_data[0];
                default: ;
            endcase
        end else if (tick) begin
            if (oneshot_q && at_tc && !pass_tc_q) begin
                state_d = ST_HALT_TC;
                done_d  = 1'b1;
            end else begin
                cnt_en_d = 1'b1;
            end
            pass_tc_d = 1'b0;
        end
    end

    // Register all state and outputs; reset aborts any pending pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_STOPPED;
            presc_q    <= '0;
            cnt_up_q   <= 1'b1;
            oneshot_q  <= 1'b0;
            pass_tc_q  <= 1'b0;
            cnt_en_q   <= 1'b0;
            cnt_load_q <= 1'b0;
            load_val_q <= 4'd0;
            cnt_clr_q  <= 1'b0;
            done_q     <= 1'b0;
            cmd_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            presc_q    <= presc_d;
            cnt_up_q   <= cnt_up_d;
            oneshot_q  <= oneshot_d;
            pass_tc_q  <= pass_tc_d;
            cnt_en_q   <= cnt_en_d;
            cnt_load_q <= cnt_load_d;
            load_val_q <= load_val_d;
            cnt_clr_q  <= cnt_clr_d;
            done_q     <= done_d;
            cmd_err_q  <= cmd_err_d;
        end
    end

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// Bench for counter_seq_ctrl: emulates the mod-12 counter, runs directed and
// random commands and checks every cycle against a behavioural model.
module tb_counter_seq_ctrl;

    localparam int MOD = 12;
    localparam int DIV = 4;
    localparam int PW  = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [2:0] cmd_op = 3'd0;
    logic [3:0] cmd_data = 4'd0;
    logic [3:0] count = 4'd0;
    logic       cmd_ready, cnt_en, cnt_up, cnt_load, cnt_clr, done, cmd_err;
    logic [3:0] load_val;
    logic [1:0] state;

    counter_seq_ctrl #(.MOD(MOD), .PRESC_DIV(DIV), .PRESC_W(PW)) dut (
        .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .count(count), .cnt_en(cnt_en),
        .cnt_up(cnt_up), .cnt_load(cnt_load), .load_val(load_val),
        .cnt_clr(cnt_clr), .state(state), .done(done), .cmd_err(cmd_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Behavioural model: mode name, cycles since the last prescale restart,
    // direction, one-shot flag and expected pulses on the wires.
    int m_state, m_phase, m_cnt, e_ldval;
    bit m_up, m_os, m_pass, e_en, e_load, e_clr, e_done, e_err;
    int env_cnt = 0;
    int en_seen = 0;
    int done_seen = 0;

    task automatic check(string name, int act, int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_state = 0; m_phase = 0; m_up = 1; m_os = 0; m_pass = 0;
        e_en = 0; e_load = 0; e_clr = 0; e_done = 0; e_err = 0; e_ldval = 0;
    endtask

    // One clock edge of the model, from the command seen at that edge.
    task automatic model_edge(bit v, int op, int data);
        int  next_cnt;
        bit  tc, tick;
        next_cnt = m_cnt;
        if (e_clr)       next_cnt = 0;
        else if (e_load) next_cnt = e_ldval;
        else if (e_en)   next_cnt = m_up ? (m_cnt + 1) % MOD : (m_cnt + MOD - 1) % MOD;
        tc   = m_up ? (m_cnt == MOD - 1) : (m_cnt == 0);
        tick = (m_state == 1) && (m_phase == DIV - 1);
        e_en = 0; e_load = 0; e_clr = 0; e_done = 0; e_err = 0;
        if (m_state == 1) m_phase = (m_phase + 1) % DIV;
        if (m_state == 2) begin
            e_en = 1; m_state = 0;
        end else if (v) begin
            case (op)
                1: if (m_state != 1) begin m_pass = (m_state == 3); m_state = 1; m_phase = 0; end
                2: if (m_state != 0) begin m_state = 0; m_phase = 0; m_pass = 0; end
                3: if (m_state != 1) begin m_state = 2; m_pass = 0; end
                4: begin
                    if (data < MOD) begin
                        e_load = 1; e_ldval = data; m_phase = 0; m_pass = 0;
                    end else e_err = 1;
                    if (m_state == 3) m_state = 0;
                end
                5: begin
                    e_clr = 1; m_phase = 0; m_pass = 0;
                    if (m_state == 3) m_state = 0;
                end
                6: m_up = data[0];
                7: m_os = data[0];
                default: ;
            endcase
        end else if (tick) begin
            if (m_os && tc && !m_pass) begin m_state = 3; e_done = 1; end
            else e_en = 1;
            m_pass = 0;
        end
        m_cnt = next_cnt;
    endtask

    // One bus cycle: drive at negedge, step model at posedge, compare after.
    task automatic cycle(bit v, int op, int data);
        bit pe, pl, pc, pu;
        int pv;
        @(negedge clk);
        cmd_valid = v; cmd_op = op[2:0]; cmd_data = data[3:0];
        pe = cnt_en; pl = cnt_load; pc = cnt_clr; pu = cnt_up; pv = load_val;
        @(posedge clk);
        model_edge(v, op, data);
        #1;
        if (pc)      env_cnt = 0;
        else if (pl) env_cnt = pv;
        else if (pe) env_cnt = pu ? (env_cnt + 1) % MOD : (env_cnt + MOD - 1) % MOD;
        count = env_cnt[3:0];
        check("cnt_en", cnt_en, e_en);
        check("cnt_load", cnt_load, e_load);
        check("cnt_clr", cnt_clr, e_clr);
        check("load_val", load_val, e_ldval);
        check("cnt_up", cnt_up, m_up);
        check("state", state, m_state);
        check("done", done, e_done);
        check("cmd_err", cmd_err, e_err);
        check("cmd_ready", cmd_ready, m_state != 2);
        check("count", env_cnt, m_cnt);
        if (cnt_en) en_seen++;
        if (done) done_seen++;
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle(0, 0, 0);
    endtask

    initial begin
        int base, k;
        model_reset();
        m_cnt = 0;
        #12;
        check("rst_state", state, 0);
        check("rst_cnt_up", cnt_up, 1);
        check("rst_pulses", {cnt_en, cnt_load, cnt_clr, done, cmd_err}, 0);
        check("rst_load_val", load_val, 0);
        check("rst_ready", cmd_ready, 1);
        reset = 1'b0;

        // Continuous run: 12 ticks in 48 cycles, counter back to 0.
        cycle(1, 1, 0);
        base = en_seen;
        idle(49);
        check("run_pulses", en_seen - base, 12);
        check("run_wrap_cnt", env_cnt, 0);
        check("run_state", state, 1);

        // One-shot from 10 up: one step to 11, then halt with done.
        cycle(1, 2, 0);
        cycle(1, 7, 1);
        cycle(1, 4, 10);
        base = done_seen;
        cycle(1, 1, 0);
        idle(10);
        check("os_state", state, 3);
        check("os_done", done_seen - base, 1);
        check("os_cnt", env_cnt, 11);

        // RUN from HALT_TC steps through the wrap.
        cycle(1, 1, 0);
        idle(5);
        check("halt_wrap_cnt", env_cnt, 0);
        check("halt_wrap_state", state, 1);
        cycle(1, 2, 0);

        // STEP held for three cycles, then two idle cycles.
        base = en_seen;
        cycle(1, 3, 0);
        check("step_ready_low", cmd_ready, 0);
        cycle(1, 3, 0);
        cycle(1, 3, 0);
        check("step_window_en", en_seen - base, 1);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        check("step_cnt", env_cnt, 2);

        // LOAD 9 while running restarts the prescaler.
        cycle(1, 7, 0);
        cycle(1, 1, 0);
        idle(2);
        cycle(1, 4, 9);
        check("load_pulse", cnt_load, 1);
        check("load_value", load_val, 9);
        k = 0;
        for (int i = 1; i <= 10 && k == 0; i++) begin
            cycle(0, 0, 0);
            if (cnt_en) k = i;
        end
        check("load_next_tick", k, DIV);
        idle(3);
        cycle(1, 2, 0);
        check("stop_on_tick_en", cnt_en, 0);
        check("stop_on_tick_state", state, 0);
        cycle(1, 4, 12);
        check("load_bad_err", cmd_err, 1);
        check("load_bad_noload", cnt_load, 0);

        // Count down from 0 in one-shot halts on the first tick.
        cycle(1, 5, 0);
        cycle(1, 7, 1);
        cycle(1, 6, 0);
        cycle(1, 1, 0);
        idle(4);
        check("down_halt_state", state, 3);
        check("down_halt_done", done, 1);

        // Random commands.
        for (int i = 0; i < 1500; i++)
            cycle(1'($urandom_range(0, 1)), int'($urandom_range(0, 7)), int'($urandom_range(0, 15)));

        // Reset while running mid-prescale.
        cycle(1, 7, 0);
        cycle(1, 1, 0);
        idle(2);
        #1 reset = 1'b1;
        #1;
        check("arst_state", state, 0);
        check("arst_cnt_up", cnt_up, 1);
        check("arst_pulses", {cnt_en, cnt_load, cnt_clr, done, cmd_err}, 0);
        reset = 1'b0;
        model_reset();
        base = en_seen;
        idle(8);
        check("arst_no_stray", en_seen - base, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
